// File: rtl/spi_master.sv
// Byte-wide SPI master: sclk idles low, mosi launched on sclk rise, miso sampled on sclk fall.
// Bit 0 of each byte goes on the wire first; slave select can be held across a burst of bytes.
module spi_master #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_hold,
  input  logic       i_release,
  input  logic [0:7] i_tx_data,
  output logic [0:7] o_rx_data,
  output logic       o_done,
  output logic       o_busy,
  output logic       o_ss,
  output logic       o_sclk,
  output logic       o_mosi,
  input  logic       i_miso
);

  localparam int unsigned CW = $clog2(CLKDIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_DESEL = 3'd6;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [0:7]    r_tx;
  logic [0:7]    r_rx;
  logic [0:7]    r_rx_data;
  logic          r_hold;
  logic          r_miso;
  logic          r_mosi;
  logic          w_cnt_done;
  logic          w_entry;
  logic          w_sample;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_done  = (r_cnt == '0);
    w_bit_nxt   = r_bit + {2'b00, (r_state == S_LOW)};
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_SETUP;
      S_SETUP: if (w_cnt_done) w_state_nxt = S_HIGH;
      S_HIGH:  if (w_cnt_done) w_state_nxt = S_LOW;
      // The last falling edge is followed straight away by END, not a full low phase.
      S_LOW: begin
        if (r_bit == 3'd7)   w_state_nxt = S_END;
        else if (w_cnt_done) w_state_nxt = S_HIGH;
      end
      S_END:   w_state_nxt = r_hold ? S_HOLD : S_DESEL;
      S_HOLD: begin
        if (i_release)    w_state_nxt = S_DESEL;
        else if (i_start) w_state_nxt = S_SETUP;
      end
      S_DESEL: if (w_cnt_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_entry  = (w_state_nxt != r_state);
  assign w_sample = (r_state == S_LOW) && (r_cnt == RELOAD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_hold    <= 1'b0;
      r_miso    <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      r_miso  <= i_miso;
      r_state <= w_state_nxt;
      if (w_entry)            r_cnt <= RELOAD;
      else if (!w_cnt_done)   r_cnt <= r_cnt - CW'(1);
      if (w_entry && w_state_nxt == S_SETUP) begin
        r_tx   <= i_tx_data;
        r_hold <= i_hold;
        r_bit  <= '0;
      end
      if (w_entry && w_state_nxt == S_HIGH) begin
        r_bit  <= w_bit_nxt;
        r_mosi <= r_tx[w_bit_nxt];
      end
      if (w_entry && w_state_nxt == S_IDLE) r_mosi <= 1'b0;
      if (w_sample) begin
        r_rx[r_bit] <= r_miso;
        if (r_bit == 3'd7) r_rx_data <= {r_rx[0:6], r_miso};
      end
    end
  end

  assign o_ss      = !((r_state == S_IDLE) || (r_state == S_DESEL));
  assign o_busy    = !((r_state == S_IDLE) || (r_state == S_HOLD));
  assign o_sclk    = (r_state == S_HIGH);
  assign o_done    = (r_state == S_END);
  assign o_mosi    = r_mosi;
  assign o_rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: CLKDIV=4 instance with loopback/slave model on miso,
// plus a CLKDIV=1 instance with miso tied low.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start4, hold4, rel4;
  logic [0:7] tx4, rx4;
  logic       done4, busy4, ss4, sclk4, mosi4, miso4;
  logic [1:0] mode;

  logic       start1;
  logic [0:7] tx1, rx1;
  logic       done1, busy1, ss1, sclk1, mosi1;

  spi_master #(.CLKDIV(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_hold(hold4), .i_release(rel4),
    .i_tx_data(tx4), .o_rx_data(rx4), .o_done(done4), .o_busy(busy4), .o_ss(ss4),
    .o_sclk(sclk4), .o_mosi(mosi4), .i_miso(miso4)
  );

  spi_master #(.CLKDIV(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_hold(1'b0), .i_release(1'b0),
    .i_tx_data(tx1), .o_rx_data(rx1), .o_done(done1), .o_busy(busy1), .o_ss(ss1),
    .o_sclk(sclk1), .o_mosi(mosi1), .i_miso(1'b0)
  );

  // Slave model: launches on sclk rise, samples on fall, answers one byte later with rx ^ 8'h5A.
  logic [0:7] s_out, s_in, s_last;
  int         s_idx = 0;
  logic       s_miso = 1'b0;

  always @(posedge ss4) begin
    s_out = '0;
    s_idx = 0;
  end
  always @(posedge sclk4) s_miso = s_out[s_idx];
  always @(negedge sclk4) begin
    if (s_idx >= 0 && s_idx < 8) s_in[s_idx] = mosi4;
    if (s_idx >= 7) begin
      s_out  = s_in ^ 8'h5A;
      s_last = s_in;
      s_idx  = 0;
    end else begin
      s_idx++;
    end
  end

  assign miso4 = (mode == 2'd0) ? mosi4 : s_miso;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event monitor for the CLKDIV=4 instance, cycle numbers relative to t_base.
  logic       mon_on = 1'b0;
  int         t_base = 0;
  int         nrise, ndone, nssfall, nssrise, nbusyrise, nbusyfall;
  int         rise_cyc[0:15];
  logic [0:15] stream;
  logic [0:7] rx_first, rx_last;
  int         done_cyc, ss_fall_cyc, ss_rise_cyc, busy_rise_cyc, busy_fall_cyc, busy_fall_first;
  logic       p_sclk = 1'b0, p_ss = 1'b0, p_busy = 1'b0;

  always @(posedge clk) begin
    int rel;
    #2;
    rel = cyc - t_base;
    if (mon_on) begin
      if (sclk4 && !p_sclk) begin
        if (nrise < 16) begin
          rise_cyc[nrise] = rel;
          stream[nrise]   = mosi4;
        end
        nrise++;
      end
      if (done4) begin
        if (ndone == 0) rx_first = rx4;
        rx_last  = rx4;
        done_cyc = rel;
        ndone++;
      end
      if (ss4 && !p_ss)   begin ss_rise_cyc = rel; nssrise++; end
      if (!ss4 && p_ss)   begin ss_fall_cyc = rel; nssfall++; end
      if (busy4 && !p_busy) begin busy_rise_cyc = rel; nbusyrise++; end
      if (!busy4 && p_busy) begin
        if (nbusyfall == 0) busy_fall_first = rel;
        busy_fall_cyc = rel;
        nbusyfall++;
      end
    end
    p_sclk = sclk4;
    p_ss   = ss4;
    p_busy = busy4;
  end

  task automatic mon_clear();
    nrise = 0; ndone = 0; nssfall = 0; nssrise = 0; nbusyrise = 0; nbusyfall = 0;
    stream = '0; rx_first = '0; rx_last = '0;
    done_cyc = -1; ss_fall_cyc = -1; ss_rise_cyc = -1;
    busy_rise_cyc = -1; busy_fall_cyc = -1; busy_fall_first = -1;
    for (int i = 0; i < 16; i++) rise_cyc[i] = -1;
    t_base = cyc;
    mon_on = 1'b1;
  endtask

  // Called at a negedge; drives start for exactly that one cycle.
  task automatic pulse4(input logic [0:7] tx, input logic hold, input logic rel);
    start4 = 1'b1;
    tx4    = tx;
    hold4  = hold;
    rel4   = rel;
    @(negedge clk);
    start4 = 1'b0;
    rel4   = 1'b0;
    tx4    = 8'h00;
    hold4  = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    while (cyc - t_base < r) @(negedge clk);
  endtask

  initial begin
    int t1, r, d1_cyc, nd1, nr1, b1_fall, ss1_fall;
    logic [0:7] d1_rx;
    logic p1;

    rst_n = 1'b0;
    start4 = 1'b0; hold4 = 1'b0; rel4 = 1'b0; tx4 = 8'h00; mode = 2'd0;
    start1 = 1'b0; tx1 = 8'h00;
    repeat (3) @(negedge clk);

    chk_eq("rst_ss",   32'(ss4),   0);
    chk_eq("rst_sclk", 32'(sclk4), 0);
    chk_eq("rst_mosi", 32'(mosi4), 0);
    chk_eq("rst_busy", 32'(busy4), 0);
    chk_eq("rst_done", 32'(done4), 0);
    chk_eq("rst_rx",   32'(rx4),   0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_clear();
    wait_rel(20);
    chk_eq("idle_no_sclk", nrise, 0);
    chk_eq("idle_ss", 32'(ss4), 0);

    // Single byte A5, loopback
    mode = 2'd0;
    mon_clear();
    pulse4(8'hA5, 1'b0, 1'b0);
    wait_rel(80);
    chk_eq("a5_ss_rise",   ss_rise_cyc, 1);
    chk_eq("a5_busy_rise", busy_rise_cyc, 1);
    chk_eq("a5_nrise",     nrise, 8);
    chk_eq("a5_rise0",     rise_cyc[0], 5);
    chk_eq("a5_rise7",     rise_cyc[7], 61);
    chk_eq("a5_mosi",      32'(stream[0:7]), 32'h A5);
    chk_eq("a5_done_cyc",  done_cyc, 66);
    chk_eq("a5_ndone",     ndone, 1);
    chk_eq("a5_rx",        32'(rx_last), 32'hA5);
    chk_eq("a5_ss_fall",   ss_fall_cyc, 67);
    chk_eq("a5_busy_fall", busy_fall_cyc, 71);
    chk_eq("a5_mosi_idle", 32'(mosi4), 0);

    // Two-byte burst against slave model
    mode = 2'd1;
    mon_clear();
    pulse4(8'h3C, 1'b1, 1'b0);
    wait_rel(70);
    chk_eq("burst_hold_busy", 32'(busy4), 0);
    chk_eq("burst_hold_ss",   32'(ss4), 1);
    pulse4(8'hC3, 1'b0, 1'b0);
    wait_rel(150);
    chk_eq("burst_busy_first", busy_fall_first, 67);
    chk_eq("burst_rise8",      rise_cyc[8], 75);
    chk_eq("burst_nrise",      nrise, 16);
    chk_eq("burst_mosi",       32'(stream), 32'h3CC3);
    chk_eq("burst_ndone",      ndone, 2);
    chk_eq("burst_rx1",        32'(rx_first), 32'h00);
    chk_eq("burst_rx2",        32'(rx_last), 32'h66);
    chk_eq("burst_slave_rx",   32'(s_last), 32'hC3);
    chk_eq("burst_nssfall",    nssfall, 1);
    chk_eq("burst_ss_fall",    ss_fall_cyc, 137);
    chk_eq("burst_busy_fall",  busy_fall_cyc, 141);

    // start while busy is ignored
    mode = 2'd0;
    mon_clear();
    pulse4(8'h5A, 1'b0, 1'b0);
    wait_rel(20);
    pulse4(8'hFF, 1'b1, 1'b0);
    wait_rel(68);
    pulse4(8'h00, 1'b1, 1'b0);
    wait_rel(90);
    chk_eq("ign_mosi",      32'(stream[0:7]), 32'h5A);
    chk_eq("ign_nrise",     nrise, 8);
    chk_eq("ign_ndone",     ndone, 1);
    chk_eq("ign_rx",        32'(rx_last), 32'h5A);
    chk_eq("ign_nssrise",   nssrise, 1);
    chk_eq("ign_busy_fall", busy_fall_cyc, 71);

    // HOLD with start and release together
    mon_clear();
    pulse4(8'h81, 1'b1, 1'b0);
    wait_rel(70);
    pulse4(8'hFF, 1'b0, 1'b1);
    wait_rel(90);
    chk_eq("rel_ss_fall",   ss_fall_cyc, 71);
    chk_eq("rel_busy_rise", busy_rise_cyc, 71);
    chk_eq("rel_busy_fall", busy_fall_cyc, 75);
    chk_eq("rel_nrise",     nrise, 8);
    chk_eq("rel_ndone",     ndone, 1);
    chk_eq("rel_rx",        32'(rx_last), 32'h81);

    // Reset mid-byte
    mon_clear();
    pulse4(8'hA5, 1'b0, 1'b0);
    wait_rel(30);
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_ss",   32'(ss4),   0);
    chk_eq("mid_rst_sclk", 32'(sclk4), 0);
    chk_eq("mid_rst_mosi", 32'(mosi4), 0);
    chk_eq("mid_rst_busy", 32'(busy4), 0);
    chk_eq("mid_rst_done", 32'(done4), 0);
    chk_eq("mid_rst_rx",   32'(rx4),   0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_rel(80);
    chk_eq("mid_rst_ndone", ndone, 0);
    chk_eq("mid_rst_nrise", nrise, 4);

    // CLKDIV=1 transfer, miso tied low
    start1 = 1'b1;
    tx1    = 8'hFF;
    t1     = cyc;
    @(negedge clk);
    start1 = 1'b0;
    d1_cyc = -1; nd1 = 0; nr1 = 0; b1_fall = -1; ss1_fall = -1; d1_rx = 8'hEE; p1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r = cyc - t1;
      if (done1) begin d1_cyc = r; d1_rx = rx1; nd1++; end
      if (sclk1 && !p1) nr1++;
      p1 = sclk1;
      if (!busy1 && b1_fall < 0) b1_fall = r;
      if (!ss1 && ss1_fall < 0) ss1_fall = r;
      @(negedge clk);
    end
    chk_eq("div1_done_cyc",  d1_cyc, 18);
    chk_eq("div1_ndone",     nd1, 1);
    chk_eq("div1_rx",        32'(d1_rx), 32'h00);
    chk_eq("div1_nrise",     nr1, 8);
    chk_eq("div1_ss_fall",   ss1_fall, 19);
    chk_eq("div1_busy_fall", b1_fall, 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
